// File: rtl/compressor_pkg.sv
// Shared constants for the row RLE compressor: FSM encoding, the row marker
// byte and the byte positions inside a token (count first, then value bytes
// MSB first).
package compressor_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;  // no open run
  localparam logic [1:0] ST_ACCUM  = 2'd1;  // run open, accepting pixels
  localparam logic [1:0] ST_EMIT   = 2'd2;  // token being serialised
  localparam logic [1:0] ST_MARKER = 2'd3;  // end-of-row marker byte

  localparam logic [7:0] ROW_MARKER = 8'h00;

  // Token byte positions: byte 0 is the run count, bytes 1..PIXEL_BYTES are
  // the pixel value starting with its most significant byte.
  localparam int TOK_COUNT_POS = 0;
  localparam int TOK_VALUE_POS = 1;

endpackage

// File: rtl/rle_emit_serializer.sv
// Serialises one {count, value} token onto the byte stream. A load captures
// the snapshot and presents the count byte on the next cycle; each consumed
// byte advances the index, and `done` flags consumption of the last byte.
module rle_emit_serializer
  import compressor_pkg::*;
#(
  parameter int PIXEL_BYTES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load,
  input  logic [7:0]               load_count,
  input  logic [8*PIXEL_BYTES-1:0] load_value,
  input  logic                     consume,
  output logic [7:0]               frame,
  output logic                     valid,
  output logic                     done
);

  localparam int TOK_BYTES = PIXEL_BYTES + 1;

  logic [7:0]               cnt_q;
  logic [8*PIXEL_BYTES-1:0] val_q;
  logic [2:0]               idx_q;
  logic                     last_byte;

  assign last_byte = (idx_q == 3'(TOK_BYTES - 1));
  assign done      = valid && consume && last_byte;

  // Snapshot load has priority so a follow-on token can start the cycle the
  // previous one finishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      val_q <= '0;
      idx_q <= '0;
      valid <= 1'b0;
    end else if (load) begin
      cnt_q <= load_count;
      val_q <= load_value;
      idx_q <= 3'(TOK_COUNT_POS);
      valid <= 1'b1;
    end else if (valid && consume) begin
      if (last_byte) begin
        valid <= 1'b0;
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + 3'd1;
      end
    end
  end

  // Byte select from registered state only, so the output holds while stalled.
  always_comb begin
    frame = 8'h00;
    if (idx_q == 3'(TOK_COUNT_POS)) frame = cnt_q;
    for (int k = 0; k < PIXEL_BYTES; k++)
      if (idx_q == 3'(TOK_VALUE_POS + k))
        frame = val_q[8*(PIXEL_BYTES-1-k) +: 8];
  end

endmodule

// File: rtl/row_rle_compressor.sv
// Row-oriented run-length compressor. Pixels are grouped into runs of equal
// symbols; each run becomes a token {count, value bytes MSB first}. Runs
// never cross a row boundary. Define ROW_MARKER_EN to append a 8'h00 marker
// byte after each row's last token.
module row_rle_compressor
  import compressor_pkg::*;
#(
  parameter int ROW_PIXELS  = 640,
  parameter int PIXEL_BYTES = 2,
  parameter int MAX_RUN     = 255
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [8*PIXEL_BYTES-1:0] i_pixel,
  input  logic                     i_valid,
  output logic                     o_in_ready,
  input  logic                     i_uart_allowed,
  output logic [7:0]               o_frame,
  output logic                     o_ready,
  output logic                     o_row_done
);

  localparam int IDX_W = $clog2(ROW_PIXELS) + 1;

  logic [1:0]               state;
  logic [8*PIXEL_BYTES-1:0] run_val;
  logic [7:0]               run_cnt;
  logic [IDX_W-1:0]         pix_idx;
  logic                     row_end;  // current row has had its last pixel
  logic                     pend;     // trailing single-pixel run still to emit
  logic                     live;     // low until the first clock after reset

  logic                     accept, last_px, extend;
  logic                     ld;
  logic [7:0]               ld_cnt;
  logic [8*PIXEL_BYTES-1:0] ld_val;
  logic [7:0]               ser_frame;
  logic                     ser_valid, ser_done;

  assign o_in_ready = live && (state == ST_IDLE || state == ST_ACCUM);
  assign accept     = i_valid && o_in_ready;
  assign last_px    = (pix_idx == IDX_W'(ROW_PIXELS - 1));
  assign extend     = (state == ST_ACCUM) && (i_pixel == run_val) &&
                      (run_cnt < 8'(MAX_RUN));

  assign o_ready = ser_valid || (state == ST_MARKER);
  assign o_frame = (state == ST_MARKER) ? ROW_MARKER : ser_frame;

  // Decide when and what to hand to the serializer.
  always_comb begin
    ld     = 1'b0;
    ld_cnt = 8'd1;
    ld_val = i_pixel;
    if (accept) begin
      if (state == ST_ACCUM && !extend) begin
        ld     = 1'b1;
        ld_cnt = run_cnt;
        ld_val = run_val;
      end else if (last_px) begin
        ld     = 1'b1;
        ld_cnt = (state == ST_ACCUM) ? run_cnt + 8'd1 : 8'd1;
      end
    end else if (state == ST_EMIT && ser_done && pend) begin
      ld     = 1'b1;
      ld_cnt = run_cnt;
      ld_val = run_val;
    end
  end

  // Run tracking, pixel index and row sequencing.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= ST_IDLE;
      run_val    <= '0;
      run_cnt    <= '0;
      pix_idx    <= '0;
      row_end    <= 1'b0;
      pend       <= 1'b0;
      live       <= 1'b0;
      o_row_done <= 1'b0;
    end else begin
      live       <= 1'b1;
      o_row_done <= 1'b0;
      case (state)
        ST_IDLE, ST_ACCUM: begin
          if (accept) begin
            pix_idx <= last_px ? '0 : pix_idx + IDX_W'(1);
            if (extend || state == ST_IDLE) begin
              if (last_px) begin
                run_cnt <= '0;
                row_end <= 1'b1;
                state   <= ST_EMIT;
              end else begin
                run_val <= i_pixel;
                run_cnt <= extend ? run_cnt + 8'd1 : 8'd1;
                state   <= ST_ACCUM;
              end
            end else begin
              run_val <= i_pixel;
              run_cnt <= 8'd1;
              state   <= ST_EMIT;
              if (last_px) begin
                pend    <= 1'b1;
                row_end <= 1'b1;
              end
            end
          end
        end
        ST_EMIT: begin
          if (ser_done) begin
            if (pend) begin
              pend    <= 1'b0;
              run_cnt <= '0;
            end else if (row_end) begin
`ifdef ROW_MARKER_EN
              state <= ST_MARKER;
`else
              row_end    <= 1'b0;
              o_row_done <= 1'b1;
              state      <= ST_IDLE;
`endif
            end else begin
              state <= ST_ACCUM;
            end
          end
        end
        ST_MARKER: begin
          if (i_uart_allowed) begin
            row_end    <= 1'b0;
            o_row_done <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  rle_emit_serializer #(.PIXEL_BYTES(PIXEL_BYTES)) u_ser (
    .clk        (CLK),
    .rst_n      (RST),
    .load       (ld),
    .load_count (ld_cnt),
    .load_value (ld_val),
    .consume    (i_uart_allowed),
    .frame      (ser_frame),
    .valid      (ser_valid),
    .done       (ser_done)
  );

endmodule

// File: tb/tb_row_rle_compressor.sv
// Bench for row_rle_compressor: two instances (8-pixel rows / MAX_RUN 255,
// and 4-pixel rows / MAX_RUN 3) driven by directed rows. A run-length model
// builds the expected byte stream; one compare process checks every
// transferred byte, every o_row_done pulse and output stability under stall.
module tb_row_rle_compressor;

  typedef int iq_t[$];
  typedef logic [15:0] pq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] pix = '0;
  logic        va = 1'b0, vb = 1'b0, ua = 1'b1;
  logic [7:0]  fa, fb;
  logic        ra, rb, ira, irb, da, db;

  int checks = 0, errors = 0;
  int umode = 0, ucyc = 0;
  int exp_a[$], exp_b[$];
  logic       stall[2];
  logic [7:0] pfr[2];

  always #5 clk = ~clk;

  row_rle_compressor #(.ROW_PIXELS(8), .PIXEL_BYTES(2), .MAX_RUN(255)) dut_a (
    .CLK(clk), .RST(rst_n), .i_pixel(pix), .i_valid(va), .o_in_ready(ira),
    .i_uart_allowed(ua), .o_frame(fa), .o_ready(ra), .o_row_done(da));

  row_rle_compressor #(.ROW_PIXELS(4), .PIXEL_BYTES(2), .MAX_RUN(3)) dut_b (
    .CLK(clk), .RST(rst_n), .i_pixel(pix), .i_valid(vb), .o_in_ready(irb),
    .i_uart_allowed(ua), .o_frame(fb), .o_ready(rb), .o_row_done(db));

  // Downstream acceptance pattern: always, one cycle in three, or never.
  always @(posedge clk) begin
    #1;
    ucyc++;
    case (umode)
      0:       ua = 1'b1;
      1:       ua = (ucyc % 3 == 0);
      default: ua = 1'b0;
    endcase
  end

  // Split a row into maximal runs of equal pixels, capped at mr.
  function automatic iq_t encode(input pq_t px, input int mr);
    iq_t q;
    int i, j;
    logic [15:0] v;
    i = 0;
    while (i < px.size()) begin
      j = i;
      while (j < px.size() && px[j] == px[i] && (j - i) < mr) j++;
      v = px[i];
      q.push_back(j - i);
      q.push_back(int'(v[15:8]));
      q.push_back(int'(v[7:0]));
      i = j;
    end
    return q;
  endfunction

  function automatic int pop(input int sel);
    if (sel == 0) return (exp_a.size() > 0) ? exp_a.pop_front() : -2;
    return (exp_b.size() > 0) ? exp_b.pop_front() : -2;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic pin(input string nm, input iq_t got, input iq_t want);
    bit bad;
    bad = (got.size() != want.size());
    if (!bad) foreach (want[k]) if (got[k] != want[k]) bad = 1;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s: model gave %p, want %p", nm, got, want);
    end
  endtask

  // Expected entries: 0..255 data byte, -1 row_done pulse, -2 nothing expected.
  task automatic obs(input int sel, input logic rdy, input logic [7:0] fr, input logic dn);
    int e;
    if (stall[sel]) begin
      checks++;
      if (!rdy || fr != pfr[sel]) begin
        errors++;
        $display("FAIL hold_%0d: ready=%0b frame=%02h, want ready=1 frame=%02h", sel, rdy, fr, pfr[sel]);
      end
    end
    if (dn) begin
      e = pop(sel);
      chk($sformatf("row_done_%0d", sel), -1, e);
    end
    if (rdy && ua) begin
      e = pop(sel);
      chk($sformatf("byte_%0d", sel), int'(fr), e);
    end
    stall[sel] = rdy && !ua;
    pfr[sel]   = fr;
  endtask

  // The single compare process.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall[0] = 1'b0;
      stall[1] = 1'b0;
    end else begin
      obs(0, ra, fa, da);
      obs(1, rb, fb, db);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pixel(input int sel, input logic [15:0] p);
    int t = 0;
    while (!(sel ? irb : ira)) begin
      tick();
      t++;
      if (t > 300) begin
        errors++;
        $display("FAIL in_ready_timeout_%0d: got 0, want 1", sel);
        return;
      end
    end
    pix = p;
    if (sel) vb = 1'b1; else va = 1'b1;
    tick();
    va = 1'b0;
    vb = 1'b0;
  endtask

  task automatic send_row(input int sel, input pq_t px, input int gap);
    iq_t q;
    q = encode(px, sel ? 3 : 255);
    foreach (q[k]) if (sel) exp_b.push_back(q[k]); else exp_a.push_back(q[k]);
`ifdef ROW_MARKER_EN
    if (sel) exp_b.push_back(0); else exp_a.push_back(0);
`endif
    if (sel) exp_b.push_back(-1); else exp_a.push_back(-1);
    foreach (px[k]) begin
      push_pixel(sel, px[k]);
      repeat (gap) tick();
    end
  endtask

  task automatic drain();
    int t = 0;
    while (exp_a.size() > 0 || exp_b.size() > 0) begin
      tick();
      t++;
      if (t > 3000) begin
        errors++;
        $display("FAIL drain_timeout: got %0d pending, want 0", exp_a.size() + exp_b.size());
        exp_a.delete();
        exp_b.delete();
        return;
      end
    end
    repeat (3) tick();
  endtask

  initial begin
    pq_t r031, r032, r_last, r_alt, b034, b_max, b_mix;
    r031   = '{16'hA155, 16'hA155, 16'hA155, 16'hA155, 16'hA155, 16'hA155, 16'hA155, 16'hA155};
    r032   = '{16'h1111, 16'h1111, 16'h2222, 16'h3333, 16'h3333, 16'h3333, 16'h3333, 16'h3333};
    r_last = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB};
    r_alt  = '{16'h0102, 16'h0304, 16'h0102, 16'h0304, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234};
    b034   = '{16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hBBBB};
    b_max  = '{16'h0707, 16'h0707, 16'h0707, 16'h0707};
    b_mix  = '{16'h5A5A, 16'hC3C3, 16'hC3C3, 16'hC3C3};

    // Hand-computed pins on the model itself.
    pin("model_031", encode(r031, 255), '{8, 'hA1, 'h55});
    pin("model_032", encode(r032, 255), '{2, 'h11, 'h11, 1, 'h22, 'h22, 5, 'h33, 'h33});
    pin("model_034", encode(b034, 3),   '{3, 'hAA, 'hAA, 1, 'hBB, 'hBB});
    pin("model_max", encode(b_max, 3),  '{3, 'h07, 'h07, 1, 'h07, 'h07});

    // Reset state.
    repeat (3) tick();
    chk("rst_ready_a", ra, 0);
    chk("rst_in_ready_a", ira, 0);
    chk("rst_frame_a", fa, 0);
    chk("rst_row_done_a", da, 0);
    chk("rst_ready_b", rb, 0);
    chk("rst_in_ready_b", irb, 0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_clk", ira, 0);
    tick();
    chk("in_ready_after_clk", ira, 1);

    // Main function, free-flowing output.
    send_row(0, r031, 0);   drain();
    send_row(0, r032, 0);   drain();
    send_row(0, r_last, 0); drain();
    send_row(0, r032, 3);   drain();
    send_row(1, b034, 0);   drain();
    send_row(1, b_max, 0);  drain();

    // Throttled output: same streams, frame must hold while stalled.
    umode = 1;
    send_row(0, r032, 0);   drain();
    send_row(0, r_alt, 0);  drain();
    send_row(1, b_mix, 1);  drain();
    send_row(1, b034, 0);   drain();
    umode = 0;

    // Back-to-back rows without draining in between.
    send_row(0, r_last, 0);
    send_row(0, r031, 0);
    drain();

    // Reset while a token is waiting on the UART.
    umode = 2;
    tick();
    push_pixel(0, 16'h1111);
    push_pixel(0, 16'h2222);
    repeat (2) tick();
    chk("emit_ready_before_rst", ra, 1);
    chk("emit_in_ready_low", ira, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_emit_rst_ready", ra, 0);
    chk("mid_emit_rst_frame", fa, 0);
    exp_a.delete();
    exp_b.delete();
    umode = 0;
    tick();
    rst_n = 1'b1;
    tick();
    send_row(0, r032, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global safety net.
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/row_rle_compressor.md
ROW_RLE_COMPRESSOR -- requirements
Module: row_rle_compressor

Interface
REQ-001 SHALL have parameter ROW_PIXELS, default 640: pixels per frame row.
REQ-002 SHALL have parameter PIXEL_BYTES, default 2 (YUV422 Y+U/V), range 1..4: bytes per pixel symbol.
REQ-003 SHALL have parameter MAX_RUN, default 255, range 2..255: longest run one token encodes.
REQ-004 SHALL have port CLK  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port RST  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_pixel  input  8*PIXEL_BYTES  pixel symbol, MSB byte first on output.
REQ-007 SHALL have port i_valid  input  1  i_pixel valid this cycle.
REQ-008 SHALL have port o_in_ready  output  1  block accepts i_pixel this cycle.
REQ-009 SHALL have port i_uart_allowed  input  1  downstream UART consumes o_frame this cycle.
REQ-010 SHALL have port o_frame  output  8  encoded byte.
REQ-011 SHALL have port o_ready  output  1  o_frame valid.
REQ-012 SHALL have port o_row_done  output  1  one-cycle pulse after last byte of a row is consumed.

Function
REQ-013 SHALL accept a pixel only when i_valid && o_in_ready; SHALL transfer a byte only when o_ready && i_uart_allowed.
REQ-014 SHALL hold o_frame stable while o_ready && !i_uart_allowed.
REQ-015 SHALL encode each run as one token: count byte (1..MAX_RUN), then PIXEL_BYTES value bytes, MSB byte first.
REQ-016 SHALL use states IDLE (no open run), ACCUM (run open), EMIT (serialising token), MARKER (row marker, REQ-028).
REQ-017 IDLE: accepted pixel opens run, count=1, pixel index +1 -> ACCUM.
REQ-018 ACCUM: accepted pixel equal to run value and count<MAX_RUN SHALL increment count and stay in ACCUM.
REQ-019 ACCUM: accepted pixel differing, or count==MAX_RUN, SHALL copy run into emit snapshot, open new run (count=1) with that pixel -> EMIT.
REQ-020 Accepted pixel that is the ROW_PIXELS-th of the row SHALL close the run that includes it; if it also differs (REQ-019), old run emits first, then single-pixel run (count 1), then MARKER/IDLE.
REQ-021 First byte of a token SHALL present o_ready the cycle after the closing pixel is accepted.
REQ-022 o_in_ready SHALL be 1 in IDLE and ACCUM, 0 in EMIT and MARKER.
REQ-023 Pixel index SHALL be $clog2(ROW_PIXELS)+1 bits and wrap to 0 after row end; run counter 8 bits, never 0 in a token.
REQ-024 After the final byte of a row is consumed: o_row_done pulses, state -> IDLE.
REQ-025 i_valid low SHALL not close a run; open runs persist indefinitely.

Reset
REQ-026 RST low SHALL asynchronously force: o_frame=0, o_ready=0, o_in_ready=0, o_row_done=0, counters=0, state IDLE; partial run discarded.
REQ-027 o_in_ready SHALL rise the first cycle after RST deasserts.

Configuration
REQ-028 With ROW_MARKER_EN defined, SHALL emit one byte 8'h00 (MARKER state) after each row's last token, before o_row_done; without it, MARKER is absent and o_row_done follows the last token directly.

Structure
REQ-029 Shared package compressor_pkg SHALL hold state encoding, ROW_MARKER byte constant (8'h00), and token byte-order constants.
REQ-030 Token serialisation SHALL be a sub-module rle_emit_serializer (snapshot load, byte index, valid/ready output).

Verification
REQ-031 ROW_PIXELS=8, PIXEL_BYTES=2: 8 pixels 16'hA155, i_uart_allowed=1 -> 08 A1 55, then 00 if ROW_MARKER_EN, then o_row_done.
REQ-032 ROW_PIXELS=8: pixels 1111,1111,2222,3333x5 -> 02 11 11, 01 22 22, 05 33 33.
REQ-033 MAX_RUN=4, ROW_PIXELS=8: 8 identical 16'h0707 -> 04 07 07, 04 07 07.
REQ-034 ROW_PIXELS=4: AAAA x3 then BBBB as last pixel -> 03 AA AA, 01 BB BB, marker, one o_row_done.
REQ-035 i_uart_allowed toggled 1-of-3 cycles during REQ-032 -> identical byte sequence, o_frame stable while stalled.
REQ-036 RST asserted mid-EMIT -> o_ready=0 immediately; next row encodes from count 1 with no residual bytes.
